// File: rtl/sw_cond.sv
// sw_cond: switch conditioner for the single-cycle CPU board top.
// Synchronises and debounces the raw slide switches, produces per-switch
// rise/fall pulses, and generates the CPU clock-enable tick. The tick is
// either free-running (fast/slow period) or single-stepped from a switch.

module sw_cond #(
    parameter int SW_W          = 16,
    parameter int DB_TICK       = 1_000_000,
    parameter int TICK_FAST     = 2**25,
    parameter int TICK_SLOW     = 2**27,
    parameter int SPEED_BIT     = 15,
    parameter int STEP_MODE_BIT = 10,
    parameter int STEP_BIT      = 9
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [SW_W-1:0] sw_i,
    output logic [SW_W-1:0] sw_o,
    output logic [SW_W-1:0] sw_rise_o,
    output logic [SW_W-1:0] sw_fall_o,
    output logic            cpu_tick_o
);

    localparam int DBW  = $clog2(DB_TICK);
    localparam int TMAX = (TICK_SLOW > TICK_FAST) ? TICK_SLOW : TICK_FAST;
    localparam int TCW  = $clog2(TMAX);

    localparam logic [DBW-1:0] DB_LAST   = DBW'(DB_TICK - 1);
    localparam logic [TCW-1:0] FAST_LAST = TCW'(TICK_FAST - 1);
    localparam logic [TCW-1:0] SLOW_LAST = TCW'(TICK_SLOW - 1);

    logic [SW_W-1:0] sync1;
    logic [SW_W-1:0] sync2;
    // hist0 is the most recent stored sample, hist1 the one before it;
    // together with the incoming sample they form the 3-deep history.
    logic [SW_W-1:0] hist0;
    logic [SW_W-1:0] hist1;
    logic [DBW-1:0]  dbc;
    logic            strobe;
    logic [SW_W-1:0] accept;
    logic            restart;
    logic [TCW-1:0]  tc;
    logic [TCW-1:0]  tc_last;

    assign strobe  = (dbc == DB_LAST);
    // A bit flips when the incoming sample and both stored samples agree
    // on a level different from the currently reported one.
    assign accept  = strobe ? (~(sync2 ^ hist0) & ~(sync2 ^ hist1) & (sync2 ^ sw_o))
                            : '0;
    // Any accepted change of the speed or mode switch restarts the period.
    assign restart = accept[SPEED_BIT] | accept[STEP_MODE_BIT];
    assign tc_last = sw_o[SPEED_BIT] ? SLOW_LAST : FAST_LAST;

    // Two-flop synchroniser for the asynchronous switch inputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= sw_i;
            sync2 <= sync1;
        end
    end

    // Free-running debounce sample counter; strobe marks its last count.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dbc <= '0;
        end else if (strobe) begin
            dbc <= '0;
        end else begin
            dbc <= dbc + 1'b1;
        end
    end

    // Shift the synchronised levels into the sample history on each strobe.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hist0 <= '0;
            hist1 <= '0;
        end else if (strobe) begin
            hist0 <= sync2;
            hist1 <= hist0;
        end
    end

    // Debounced levels and their one-cycle edge pulses, updated together.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sw_o      <= '0;
            sw_rise_o <= '0;
            sw_fall_o <= '0;
        end else begin
            sw_o      <= sw_o ^ accept;
            sw_rise_o <= accept & sync2;
            sw_fall_o <= accept & ~sync2;
        end
    end

    // CPU tick: period counter in run mode, step pulse in step mode. A
    // mode-entry pulse still present means the mode was off last cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tc         <= '0;
            cpu_tick_o <= 1'b0;
        end else if (restart) begin
            tc         <= '0;
            cpu_tick_o <= 1'b0;
        end else if (sw_o[STEP_MODE_BIT]) begin
            tc         <= '0;
            cpu_tick_o <= sw_rise_o[STEP_BIT] & ~sw_rise_o[STEP_MODE_BIT];
        end else if (tc == tc_last) begin
            tc         <= '0;
            cpu_tick_o <= 1'b1;
        end else begin
            tc         <= tc + 1'b1;
            cpu_tick_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sw_cond.sv
// tb_sw_cond: self-checking bench for sw_cond with small debounce and
// tick periods. A cycle-level behavioural model is compared against the
// DUT every cycle; directed phases pin latencies and periods to literals.

module tb_sw_cond;

    localparam int SW_W = 16;
    localparam int DB   = 4;
    localparam int TF   = 8;
    localparam int TS   = 16;

    logic            clk  = 1'b0;
    logic            rstn = 1'b0;
    logic [SW_W-1:0] sw_i = '0;
    logic [SW_W-1:0] sw_o;
    logic [SW_W-1:0] sw_rise_o;
    logic [SW_W-1:0] sw_fall_o;
    logic            cpu_tick_o;

    int total     = 0;
    int bad       = 0;
    int dut_ticks = 0;

    always #5 clk = ~clk;

    sw_cond #(
        .SW_W(SW_W), .DB_TICK(DB), .TICK_FAST(TF), .TICK_SLOW(TS),
        .SPEED_BIT(15), .STEP_MODE_BIT(10), .STEP_BIT(9)
    ) dut (
        .clk(clk), .rstn(rstn), .sw_i(sw_i), .sw_o(sw_o),
        .sw_rise_o(sw_rise_o), .sw_fall_o(sw_fall_o), .cpu_tick_o(cpu_tick_o)
    );

    task automatic check_output(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Behavioural model state: expected outputs after each edge.
    logic [SW_W-1:0] m_sw   = '0;
    logic [SW_W-1:0] m_rise = '0;
    logic [SW_W-1:0] m_fall = '0;
    logic            m_tick = 1'b0;
    logic [SW_W-1:0] in_q[$];
    logic [SW_W-1:0] smp_q[$];
    logic [SW_W-1:0] sync_now, acc, prev_sw, prev_rise;
    logic            strobe_m, restart_m;
    int              edge_n = 0;
    int              since  = 0;
    int              period = TF;

    // Model update on each rising edge, then compare all outputs.
    always @(posedge clk) begin
        if (!rstn) begin
            m_sw   = '0;
            m_rise = '0;
            m_fall = '0;
            m_tick = 1'b0;
            in_q.delete();
            smp_q.delete();
            smp_q.push_back('0);
            smp_q.push_back('0);
            edge_n = 0;
            since  = 0;
        end else begin
            sync_now = (in_q.size() >= 2) ? in_q[in_q.size()-2] : '0;
            in_q.push_back(sw_i);
            if (in_q.size() > 2) void'(in_q.pop_front());
            strobe_m = ((edge_n % DB) == DB - 1);
            edge_n++;
            acc = '0;
            if (strobe_m) begin
                for (int i = 0; i < SW_W; i++) begin
                    if (sync_now[i] == smp_q[1][i] && sync_now[i] == smp_q[0][i]
                        && sync_now[i] != m_sw[i])
                        acc[i] = 1'b1;
                end
                smp_q.push_back(sync_now);
                void'(smp_q.pop_front());
            end
            prev_sw   = m_sw;
            prev_rise = m_rise;
            restart_m = acc[15] | acc[10];
            period    = prev_sw[15] ? TS : TF;
            if (restart_m) begin
                m_tick = 1'b0;
                since  = 0;
            end else if (prev_sw[10]) begin
                since  = 0;
                m_tick = prev_rise[9] && !prev_rise[10];
            end else begin
                since++;
                m_tick = (since == period);
                if (m_tick) since = 0;
            end
            m_sw   = m_sw ^ acc;
            m_rise = acc & sync_now;
            m_fall = acc & ~sync_now;
        end
        #1;
        check_output("model sw_o", 32'(sw_o), 32'(m_sw));
        check_output("model sw_rise_o", 32'(sw_rise_o), 32'(m_rise));
        check_output("model sw_fall_o", 32'(sw_fall_o), 32'(m_fall));
        check_output("model cpu_tick_o", 32'(cpu_tick_o), 32'(m_tick));
        if (cpu_tick_o) dut_ticks++;
    end

    task automatic wait_edge();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_pulse(input string name, input int idx, input bit rising,
                              input int limit, output int n);
        bit seen;
        seen = 1'b0;
        n    = 0;
        while (!seen && n < limit) begin
            wait_edge();
            n++;
            seen = rising ? sw_rise_o[idx] : sw_fall_o[idx];
        end
        check_output(name, 32'(seen), 32'd1);
    endtask

    task automatic wait_tick(input string name, input int limit, output int n);
        bit seen;
        seen = 1'b0;
        n    = 0;
        while (!seen && n < limit) begin
            wait_edge();
            n++;
            seen = cpu_tick_o;
        end
        check_output(name, 32'(seen), 32'd1);
    endtask

    // Directed phases: reset, bounce, run rate, step, mode exit, mid reset.
    initial begin : apply_stimulus
        int n;
        int t0;
        int r3;
        int f3;
        int rb;

        rstn = 1'b0;
        sw_i = 16'hFFFF;
        repeat (3) wait_edge();
        check_output("reset sw_o", 32'(sw_o), 32'h0);
        check_output("reset rise", 32'(sw_rise_o), 32'h0);
        check_output("reset fall", 32'(sw_fall_o), 32'h0);
        check_output("reset tick", 32'(cpu_tick_o), 32'h0);
        rstn = 1'b1;
        n = 0;
        while (sw_o == '0 && n < 20) begin
            wait_edge();
            n++;
        end
        check_output("reset accept cycle", 32'(n), 32'd12);
        check_output("reset accept sw_o", 32'(sw_o), 32'hFFFF);
        check_output("reset accept rise", 32'(sw_rise_o), 32'hFFFF);
        check_output("reset accept fall", 32'(sw_fall_o), 32'h0);
        wait_edge();
        check_output("reset rise cleared", 32'(sw_rise_o), 32'h0);
        sw_i = '0;
        n = 0;
        while (sw_o != '0 && n < 40) begin
            wait_edge();
            n++;
        end
        check_output("all released", 32'(sw_o), 32'h0);

        r3 = 0;
        f3 = 0;
        rb = 0;
        for (int k = 0; k < 14; k++) begin
            sw_i[3] = ~sw_i[3];
            repeat (3) begin
                wait_edge();
                if (sw_rise_o[3]) rb++;
                if (sw_fall_o[3]) f3++;
            end
        end
        sw_i[3] = 1'b1;
        repeat (30) begin
            wait_edge();
            if (sw_rise_o[3]) r3++;
            if (sw_fall_o[3]) f3++;
        end
        check_output("bounce rise during toggle", 32'(rb), 32'd0);
        check_output("bounce single rise", 32'(r3), 32'd1);
        check_output("bounce no fall", 32'(f3), 32'd0);
        check_output("bounce final level", 32'(sw_o[3]), 32'd1);

        wait_tick("fast sync tick", 20, n);
        wait_tick("fast tick a", 20, n);
        check_output("fast gap a", 32'(n), 32'd8);
        wait_tick("fast tick b", 20, n);
        check_output("fast gap b", 32'(n), 32'd8);
        sw_i[15] = 1'b1;
        wait_pulse("speed rise", 15, 1'b1, 20, n);
        check_output("no tick at speed change", 32'(cpu_tick_o), 32'd0);
        wait_tick("slow tick a", 40, n);
        check_output("slow first gap", 32'(n), 32'd16);
        wait_tick("slow tick b", 40, n);
        check_output("slow gap", 32'(n), 32'd16);

        sw_i[10] = 1'b1;
        sw_i[15] = 1'b0;
        wait_pulse("step mode on", 10, 1'b1, 20, n);
        t0 = dut_ticks;
        repeat (200) wait_edge();
        check_output("idle step ticks", 32'(dut_ticks - t0), 32'd0);
        t0 = dut_ticks;
        for (int k = 0; k < 3; k++) begin
            sw_i[9] = 1'b1;
            wait_pulse("step rise", 9, 1'b1, 20, n);
            check_output("step tick not same cycle", 32'(cpu_tick_o), 32'd0);
            wait_edge();
            check_output("step tick next cycle", 32'(cpu_tick_o), 32'd1);
            sw_i[9] = 1'b0;
            wait_pulse("step fall", 9, 1'b0, 20, n);
        end
        check_output("step tick count", 32'(dut_ticks - t0), 32'd3);

        sw_i[10] = 1'b0;
        wait_pulse("step mode off", 10, 1'b0, 20, n);
        check_output("no tick at mode exit", 32'(cpu_tick_o), 32'd0);
        wait_tick("exit tick", 30, n);
        check_output("exit first tick", 32'(n), 32'd8);

        wait_tick("pre reset tick", 20, n);
        repeat (5) wait_edge();
        rstn = 1'b0;
        #1;
        check_output("mid reset tick", 32'(cpu_tick_o), 32'd0);
        check_output("mid reset sw_o", 32'(sw_o), 32'h0);
        wait_edge();
        rstn = 1'b1;
        wait_tick("post reset tick", 20, n);
        check_output("post reset first", 32'(n), 32'd8);
        wait_tick("post reset tick b", 20, n);
        check_output("post reset gap", 32'(n), 32'd8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
